// File: rtl/mips_mem_arbiter_if.sv
// Requester, flush and memory-side signals of the unified-memory arbiter.
// slave = arbiter side, master = requesters plus the memory model.
interface mips_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          flush;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    owner;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter: data port beats fetch, except after STARVE_MAX
// consecutive fetch losses. One access per three cycles (grant, access, ack).
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input logic               clk1,
    input logic               rst,
    mips_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;
    localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       kill;
    logic       cur_we;
    logic       if_elig, dm_elig, grant_if, grant_dm;
    mem_req_t   win;

    // A requester whose ack is up this cycle is already served and sits out.
    always_comb begin
        if_elig   = bus.if_req & ~bus.if_ack & ~bus.flush;
        dm_elig   = bus.dm_req & ~bus.dm_ack;
        grant_if  = if_elig & (~dm_elig | (starve_cnt == SMAX));
        grant_dm  = dm_elig & ~grant_if;
        win.we    = grant_dm & bus.dm_we;
        win.addr  = grant_dm ? bus.dm_addr : bus.if_addr;
        win.wdata = grant_dm ? bus.dm_wdata : '0;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            kill          <= 1'b0;
            cur_we        <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.owner     <= OWN_NONE;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_ack    <= 1'b0;
            bus.dm_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            if (!bus.if_req)
                starve_cnt <= '0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_dm) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= win.we;
                        bus.mem_addr  <= win.addr;
                        bus.mem_wdata <= win.wdata;
                        bus.owner     <= grant_dm ? OWN_DM : OWN_IF;
                        cur_we        <= win.we;
                        state         <= WAIT;
                        if (grant_if)
                            starve_cnt <= '0;
                        else if (if_elig && starve_cnt != SMAX)
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                WAIT: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= DONE;
                    if (bus.owner == OWN_IF && bus.flush)
                        kill <= 1'b1;
                end
                DONE: begin
                    if (bus.owner == OWN_DM) begin
                        bus.dm_ack <= 1'b1;
                        if (!cur_we)
                            bus.dm_rdata <= bus.mem_rdata;
                    end else if (bus.owner == OWN_IF && !(kill || bus.flush)) begin
                        bus.if_ack   <= 1'b1;
                        bus.if_rdata <= bus.mem_rdata;
                    end
                    kill      <= 1'b0;
                    bus.owner <= OWN_NONE;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural synchronous memory.
module tb_mips_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk1 = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    mips_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [31:0] init_word(int i);
        case (i)
            5:       return 32'h2001_0003;
            8:       return 32'h8C0A_0004;
            'h20:    return 32'h1111_2222;
            'h30:    return 32'h3C01_ABCD;
            'h40:    return 32'h0000_0007;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    always @(posedge clk1) begin
        if (mem_load) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    initial begin
        int acks;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.flush = 0;
        mem_load = 1;
        tick;
        mem_load = 0;
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 0);
        chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
        rst = 0;
        tick;

        // lone fetch
        bus.if_req = 1; bus.if_addr = 10'd5;
        tick;
        chk("if_mem_en", 32'(bus.mem_en), 1);
        chk("if_mem_addr", 32'(bus.mem_addr), 5);
        chk("if_mem_we", 32'(bus.mem_we), 0);
        chk("if_owner_wait", 32'(bus.owner), 1);
        tick;
        chk("if_mem_en_off", 32'(bus.mem_en), 0);
        chk("if_owner_done", 32'(bus.owner), 1);
        tick;
        chk("if_ack", 32'(bus.if_ack), 1);
        chk("if_rdata", bus.if_rdata, 32'h2001_0003);
        bus.if_req = 0;
        tick;
        chk("if_ack_pulse", 32'(bus.if_ack), 0);

        // simultaneous requests: DM first, IF at E3
        bus.if_req = 1; bus.if_addr = 10'd8;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h40;
        tick;
        chk("sim_owner_dm", 32'(bus.owner), 2);
        chk("sim_addr_dm", 32'(bus.mem_addr), 32'h40);
        tick; tick;
        chk("sim_dm_ack", 32'(bus.dm_ack), 1);
        chk("sim_dm_rdata", bus.dm_rdata, 32'h7);
        chk("sim_no_if_ack", 32'(bus.if_ack), 0);
        bus.dm_req = 0;
        tick;
        chk("sim_owner_if", 32'(bus.owner), 1);
        chk("sim_addr_if", 32'(bus.mem_addr), 8);
        tick; tick;
        chk("sim_if_ack", 32'(bus.if_ack), 1);
        chk("sim_if_rdata", bus.if_rdata, 32'h8C0A_0004);
        bus.if_req = 0;
        tick;

        // store then load back; ack masking keeps E3 idle
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 10'h10; bus.dm_wdata = 32'hDEAD_BEEF;
        tick;
        chk("st_mem_we", 32'(bus.mem_we), 1);
        chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_addr", 32'(bus.mem_addr), 32'h10);
        tick;
        chk("st_mem_we_off", 32'(bus.mem_we), 0);
        tick;
        chk("st_dm_ack", 32'(bus.dm_ack), 1);
        chk("st_dm_rdata_hold", bus.dm_rdata, 32'h7);
        bus.dm_we = 0;
        tick;
        chk("st_ack_mask", 32'(bus.mem_en), 0);
        tick;
        chk("ld_owner", 32'(bus.owner), 2);
        tick; tick;
        chk("ld_dm_ack", 32'(bus.dm_ack), 1);
        chk("ld_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        bus.dm_req = 0;
        tick;

        // starvation: flush in each DM ack cycle keeps IF out of the free E3 slot
        bus.if_req = 1; bus.if_addr = 10'h30;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h100;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("stv_dm_win%0d", k), 32'(bus.owner), 2);
            tick; tick;
            chk($sformatf("stv_dm_ack%0d", k), 32'(bus.dm_ack), 1);
            bus.dm_addr = 10'(10'h101 + k);
            bus.flush = 1;
            tick;
            chk($sformatf("stv_gap%0d", k), 32'(bus.owner), 0);
            bus.flush = 0;
        end
        tick;
        chk("stv_if_win", 32'(bus.owner), 1);
        chk("stv_if_addr", 32'(bus.mem_addr), 32'h30);
        tick; tick;
        chk("stv_if_ack", 32'(bus.if_ack), 1);
        chk("stv_if_rdata", bus.if_rdata, 32'h3C01_ABCD);
        tick;
        chk("stv_dm_win6", 32'(bus.owner), 2);
        tick; tick;
        chk("stv_dm_ack6", 32'(bus.dm_ack), 1);
        bus.dm_addr = 10'h200;
        bus.flush = 1;
        tick;
        bus.flush = 0;
        tick;
        chk("stv_dm_win7", 32'(bus.owner), 2);
        tick; tick;
        chk("stv_dm_rdata7", bus.dm_rdata, 32'hC0DE_0200);
        bus.dm_req = 0; bus.if_req = 0;
        tick;

        // flush during WAIT kills the fetch; the next one goes through
        bus.if_req = 1; bus.if_addr = 10'h50;
        tick;
        chk("fl_owner", 32'(bus.owner), 1);
        bus.flush = 1;
        tick;
        bus.flush = 0;
        tick;
        chk("fl_no_ack", 32'(bus.if_ack), 0);
        chk("fl_rdata_hold", bus.if_rdata, 32'h3C01_ABCD);
        bus.if_addr = 10'h20;
        tick;
        chk("fl_regrant", 32'(bus.owner), 1);
        chk("fl_regrant_addr", 32'(bus.mem_addr), 32'h20);
        tick; tick;
        chk("fl_ack", 32'(bus.if_ack), 1);
        chk("fl_rdata", bus.if_rdata, 32'h1111_2222);
        bus.if_req = 0;
        tick;

        // flush in the DONE cycle also kills
        bus.if_req = 1; bus.if_addr = 10'd5;
        tick; tick;
        bus.flush = 1;
        tick;
        chk("fld_no_ack", 32'(bus.if_ack), 0);
        chk("fld_rdata_hold", bus.if_rdata, 32'h1111_2222);
        bus.flush = 0; bus.if_req = 0;
        tick;

        // DM unaffected by flush
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h40; bus.flush = 1;
        tick;
        chk("dfl_owner", 32'(bus.owner), 2);
        tick; tick;
        chk("dfl_ack", 32'(bus.dm_ack), 1);
        chk("dfl_rdata", bus.dm_rdata, 32'h7);
        bus.dm_req = 0; bus.flush = 0;
        tick;

        // async reset mid-WAIT of a store
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 10'h60; bus.dm_wdata = 32'h1234_5678;
        tick;
        chk("ar_pre_we", 32'(bus.mem_we), 1);
        #2;
        rst = 1;
        #1;
        chk("ar_mem_en", 32'(bus.mem_en), 0);
        chk("ar_mem_we", 32'(bus.mem_we), 0);
        chk("ar_owner", 32'(bus.owner), 0);
        bus.dm_req = 0;
        tick;
        rst = 0;
        acks = 0;
        repeat (5) begin
            tick;
            acks += int'(bus.dm_ack);
        end
        chk("ar_no_ack", 32'(acks), 0);
        chk("ar_no_write", mem[10'h60], 32'hC0DE_0060);
        chk("ar_dm_rdata", bus.dm_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
